// File: rtl/dmem_port_arbiter.sv
// Single-port RAM arbiter between fetch and memory stages: grants one access per cycle,
// steers read data back to its issuer, builds store strobes. Optional macro: MEM_ARB_RR_EN.
module dmem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e           resp_owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             last_d;      // 1: most recent grant went to the data port
    logic [31:0]      if_hold;
    logic [31:0]      d_hold;

    logic d_misalign;
    logic d_mis;
    logic d_valid;
    logic gnt_if;
    logic gnt_d;
    logic d_store;
    logic [3:0]  d_be;
    logic [31:0] d_lanes;

    always_comb begin
        d_misalign = 1'b0;
        unique case (d_size)
            2'b00:   d_misalign = 1'b0;
            2'b01:   d_misalign = d_addr[0];
            default: d_misalign = (d_addr[1:0] != 2'b00);
        endcase
    end

    // A misaligned request is answered (ready) but never competes for the RAM.
    assign d_mis   = rst_n & d_req & d_misalign;
    assign d_valid = d_req & ~d_misalign;

    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (rst_n) begin
            if (if_req && d_valid) begin
`ifdef MEM_ARB_RR_EN
                gnt_if = last_d;
`else
                gnt_if = (starve_cnt == CNT_MAX);
`endif
                gnt_d  = ~gnt_if;
            end else begin
                gnt_if = if_req;
                gnt_d  = d_valid;
            end
        end
    end

    always_comb begin
        d_be    = 4'b1111;
        d_lanes = d_wdata;
        unique case (d_size)
            2'b00: begin
                d_be    = 4'b0001 << d_addr[1:0];
                d_lanes = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                d_be    = 4'b0011 << {d_addr[1], 1'b0};
                d_lanes = {2{d_wdata[15:0]}};
            end
            default: begin
                d_be    = 4'b1111;
                d_lanes = d_wdata;
            end
        endcase
    end

    assign d_store   = gnt_d & d_we;
    assign if_ready  = gnt_if;
    assign d_ready   = gnt_d | d_mis;
    assign ram_en    = gnt_if | gnt_d;
    assign ram_we    = d_store ? d_be : 4'b0000;
    assign ram_wdata = d_store ? d_lanes : 32'd0;
    assign ram_addr  = gnt_if ? if_addr[ADDR_W+1:2] :
                       gnt_d  ? d_addr[ADDR_W+1:2]  : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_owner <= OWN_NONE;
            last_d     <= 1'b1;
            d_err      <= 1'b0;
        end else begin
            d_err <= d_mis;
            if (gnt_if)
                resp_owner <= OWN_IF;
            else if (gnt_d && !d_we)
                resp_owner <= OWN_D;
            else
                resp_owner <= OWN_NONE;
            if (gnt_if)
                last_d <= 1'b0;
            else if (gnt_d)
                last_d <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else begin
`ifdef MEM_ARB_RR_EN
            starve_cnt <= '0;
`else
            if (!if_req || gnt_if)
                starve_cnt <= '0;
            else if (gnt_d && starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + 1'b1;
`endif
        end
    end

    // RAM data arrives in the response cycle; it is passed straight through to the
    // owner and captured so each port keeps showing its last word afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_hold <= '0;
            d_hold  <= '0;
        end else begin
            if (resp_owner == OWN_IF) if_hold <= ram_rdata;
            if (resp_owner == OWN_D)  d_hold  <= ram_rdata;
        end
    end

    assign if_rvalid = (resp_owner == OWN_IF);
    assign d_rvalid  = (resp_owner == OWN_D);
    assign if_rdata  = if_rvalid ? ram_rdata : if_hold;
    assign d_rdata   = d_rvalid  ? ram_rdata : d_hold;

    logic unused_bits;
    assign unused_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2],
                           last_d, starve_cnt};
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural model plus RAM model, per-cycle compare, directed vectors.
module tb_dmem_port_arbiter;
    localparam int ADDR_W     = 12;
    localparam int STARVE_MAX = 4;
    localparam int WORDS      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ready, if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req, d_we;
    logic [1:0]        d_size;
    logic [31:0]       d_addr, d_wdata;
    logic              d_ready, d_rvalid, d_err;
    logic [31:0]       d_rdata;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'd0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // RAM macro model, driven only by the DUT's RAM-side outputs.
    logic [31:0] ram  [WORDS];
    logic [31:0] gold [WORDS];

    function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [3:0] be,
                                             input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) ram_rdata <= ram[ram_addr];
            else ram[ram_addr] <= apply_be(ram[ram_addr], ram_we, ram_wdata);
        end
    end

    // ---- behavioural model ----
    int          m_starve;
    logic        m_last_d;
    int          m_owner;     // 0 none, 1 fetch, 2 data
    logic [31:0] m_pend, m_if_last, m_d_last;
    logic        m_err;

    function automatic int acc_bytes();
        return (d_size == 2'b00) ? 1 : (d_size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic mis_m();
        return d_req && (d_addr % acc_bytes() != 0);
    endfunction

    function automatic int lane_off();
        return int'(d_addr[1:0]) - (int'(d_addr[1:0]) % acc_bytes());
    endfunction

    function automatic logic [3:0] strobe_m();
        logic [3:0] s;
        s = 4'b0000;
        for (int b = 0; b < 4; b++)
            if (b >= lane_off() && b < lane_off() + acc_bytes()) s[b] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] store_word_m();
        logic [31:0] w;
        w = 32'd0;
        for (int b = 0; b < 4; b++)
            if (strobe_m()) w[8*b +: 8] = 8'h00;
        for (int b = 0; b < 4; b++)
            if (b >= lane_off() && b < lane_off() + acc_bytes())
                w[8*b +: 8] = d_wdata[8*(b - lane_off()) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
        return m;
    endfunction

    // Returns {data_grant, fetch_grant}.
    function automatic logic [1:0] arb_m();
        logic dv;
        if (!rst_n) return 2'b00;
        dv = d_req && !mis_m();
        if (if_req && dv) begin
`ifdef MEM_ARB_RR_EN
            return m_last_d ? 2'b01 : 2'b10;
`else
            return (m_starve >= STARVE_MAX) ? 2'b01 : 2'b10;
`endif
        end
        return {dv, if_req};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_starve  <= 0;
            m_last_d  <= 1'b1;
            m_owner   <= 0;
            m_pend    <= 32'd0;
            m_if_last <= 32'd0;
            m_d_last  <= 32'd0;
            m_err     <= 1'b0;
        end else begin
            logic [1:0] g;
            g = arb_m();
            m_err <= mis_m();
            if (m_owner == 1) m_if_last <= m_pend;
            if (m_owner == 2) m_d_last  <= m_pend;
            m_owner <= g[0] ? 1 : (g[1] && !d_we) ? 2 : 0;
            m_pend  <= g[0] ? gold[if_addr[ADDR_W+1:2]] : gold[d_addr[ADDR_W+1:2]];
            if (g[1] && d_we)
                gold[d_addr[ADDR_W+1:2]] <= apply_be(gold[d_addr[ADDR_W+1:2]], strobe_m(),
                                                     store_word_m());
            if (g[0]) m_last_d <= 1'b0;
            else if (g[1]) m_last_d <= 1'b1;
            if (!if_req || g[0]) m_starve <= 0;
            else if (g[1] && m_starve < STARVE_MAX) m_starve <= m_starve + 1;
        end
    end

    // ---- per-cycle compare ----
    always @(negedge clk) begin
        logic [1:0] g;
        logic       st;
        g  = arb_m();
        st = g[1] && d_we;
        chk("if_ready", {31'd0, if_ready}, {31'd0, g[0]});
        chk("d_ready", {31'd0, d_ready}, {31'd0, g[1] | (rst_n && mis_m())});
        chk("ram_en", {31'd0, ram_en}, {31'd0, |g});
        chk("ram_we", {28'd0, ram_we}, {28'd0, st ? strobe_m() : 4'b0000});
        if (g[0]) chk("ram_addr_if", {20'd0, ram_addr}, {20'd0, if_addr[ADDR_W+1:2]});
        if (g[1]) chk("ram_addr_d", {20'd0, ram_addr}, {20'd0, d_addr[ADDR_W+1:2]});
        if (st) chk("ram_wdata", ram_wdata & lane_mask(strobe_m()), store_word_m());
        if (!rst_n) begin
            chk("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
            chk("rst_ram_wdata", ram_wdata, 32'd0);
        end
        chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, m_owner == 1});
        chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, m_owner == 2});
        chk("if_rdata", if_rdata, (m_owner == 1) ? m_pend : m_if_last);
        chk("d_rdata", d_rdata, (m_owner == 2) ? m_pend : m_d_last);
        chk("d_err", {31'd0, d_err}, {31'd0, m_err});
    end

    // ---- directed stimulus with literal expectations ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
    endtask

    task automatic dreq(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd);
        d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    endtask

    logic [1:0]  tv_size [8] = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00};
    logic [31:0] tv_addr [8] = '{32'h301, 32'h302, 32'h304, 32'h308, 32'h30C, 32'h307,
                                 32'h309, 32'h300};
    logic [31:0] tv_wd   [8] = '{32'hFFFF_FF5A, 32'h1234_56C3, 32'hAAAA_BEEF, 32'hCAFEF00D,
                                 32'h0BAD_F00D, 32'h0000_7777, 32'h1111_1111, 32'h0000_0099};

    initial begin
        logic [9:0] seq;
        logic [9:0] seq_exp;
        logic gi, gd;
        rst_n = 1'b0;
        if_addr = 32'd0; d_size = 2'b00; d_addr = 32'd0; d_wdata = 32'd0;
        idle();
        for (int i = 0; i < WORDS; i++) begin
            ram[i]  = {i[15:0], ~i[15:0]};
            gold[i] = {i[15:0], ~i[15:0]};
        end
        ram[4] = 32'hDEAD_BEEF;  gold[4] = 32'hDEAD_BEEF;
        ram[64] = 32'h1122_3344; gold[64] = 32'h1122_3344;

        repeat (2) @(negedge clk);
        chk("rst_ram_en_lit", {31'd0, ram_en}, 32'd0);
        chk("rst_if_rvalid_lit", {31'd0, if_rvalid}, 32'd0);
        tick(); rst_n = 1'b1;

        // fetch only
        tick(); if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        chk("fetch_ready_lit", {31'd0, if_ready}, 32'd1);
        chk("fetch_addr_lit", {20'd0, ram_addr}, 32'd4);
        tick(); idle();
        @(negedge clk);
        chk("fetch_rvalid_lit", {31'd0, if_rvalid}, 32'd1);
        chk("fetch_rdata_lit", if_rdata, 32'hDEAD_BEEF);

        // reset while a fetch read is in flight
        tick(); if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        chk("midrst_ready_lit", {31'd0, if_ready}, 32'd1);
        tick(); idle(); rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid_lit", {31'd0, if_rvalid}, 32'd0);
        chk("midrst_rdata_lit", if_rdata, 32'd0);
        tick(); rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_after_lit", {31'd0, if_rvalid}, 32'd0);

        // byte store then read back
        tick(); dreq(1'b1, 2'b00, 32'h103, 32'h0000_00A5);
        @(negedge clk);
        chk("bst_ready_lit", {31'd0, d_ready}, 32'd1);
        chk("bst_we_lit", {28'd0, ram_we}, 32'h8);
        chk("bst_lane_lit", {24'd0, ram_wdata[31:24]}, 32'hA5);
        chk("bst_addr_lit", {20'd0, ram_addr}, 32'h040);
        tick(); idle();
        @(negedge clk);
        chk("bst_rvalid_lit", {31'd0, d_rvalid}, 32'd0);
        tick(); dreq(1'b0, 2'b10, 32'h100, 32'd0);
        tick(); idle();
        @(negedge clk);
        chk("bst_rb_rvalid_lit", {31'd0, d_rvalid}, 32'd1);
        chk("bst_rb_rdata_lit", d_rdata, 32'hA522_3344);

        // half store
        tick(); dreq(1'b1, 2'b01, 32'h6, 32'h0000_1234);
        @(negedge clk);
        chk("hst_we_lit", {28'd0, ram_we}, 32'hC);
        chk("hst_lane_lit", {16'd0, ram_wdata[31:16]}, 32'h1234);
        tick(); idle();

        // misaligned word load
        tick(); dreq(1'b0, 2'b10, 32'h2, 32'd0);
        @(negedge clk);
        chk("mis_ready_lit", {31'd0, d_ready}, 32'd1);
        chk("mis_ram_en_lit", {31'd0, ram_en}, 32'd0);
        tick(); idle();
        @(negedge clk);
        chk("mis_err_lit", {31'd0, d_err}, 32'd1);
        chk("mis_rvalid_lit", {31'd0, d_rvalid}, 32'd0);
        tick();
        @(negedge clk);
        chk("mis_err_clr_lit", {31'd0, d_err}, 32'd0);

        // back-to-back store table, then back-to-back loads of the same words
        for (int i = 0; i < 8; i++) begin
            tick(); dreq(1'b1, tv_size[i], tv_addr[i], tv_wd[i]);
        end
        for (int i = 0; i < 4; i++) begin
            tick(); dreq(1'b0, 2'b10, 32'h300 + 32'(4 * i), 32'd0);
        end
        tick(); idle();

        // contention: a lone fetch first, then both ports held busy
        tick(); if_req = 1'b1; if_addr = 32'h80;
        tick(); if_addr = 32'h84; dreq(1'b0, 2'b10, 32'h200, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            gi = if_ready;
            gd = d_ready;
            seq[9 - i] = gd & ~gi;
            tick();
            if (gi) if_addr = if_addr + 32'd4;
            if (gd) d_addr = d_addr + 32'd4;
        end
`ifdef MEM_ARB_RR_EN
        seq_exp = 10'b10_1010_1010;
`else
        seq_exp = 10'b11_1101_1110;
`endif
        chk("contention_order_lit", {22'd0, seq}, {22'd0, seq_exp});
        idle();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port synchronous data/instruction RAM between the fetch stage and the memory stage.
- Grants at most one access per cycle and routes read data back to the requester that issued it.
- Converts byte/half/word stores into RAM byte strobes with lane-shifted write data, and flags misaligned data accesses.
- Sits between the fetch/memory stages and the RAM macro; its ready outputs drive pipeline stalls.

Parameters:
ADDR_W, 12, RAM word-address width; RAM holds 2^ADDR_W 32-bit words.
STARVE_MAX, 4, maximum consecutive data grants allowed while a fetch request waits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
if_req  input  1  fetch read request.
if_addr  input  32  fetch byte address; bits [1:0] ignored.
if_ready  output  1  fetch request granted this cycle (combinational).
if_rvalid  output  1  fetch read data valid (one cycle after grant).
if_rdata  output  32  fetch read data.
d_req  input  1  memory-stage request.
d_we  input  1  1 = store, 0 = load.
d_size  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
d_addr  input  32  data byte address.
d_wdata  input  32  store data, right-aligned.
d_ready  output  1  data request granted or rejected this cycle (combinational).
d_rvalid  output  1  load data valid (one cycle after grant).
d_rdata  output  32  raw RAM word; lane extraction is done downstream.
d_err  output  1  misaligned-access pulse (registered).
ram_en  output  1  RAM access enable.
ram_we  output  4  byte write strobes; bit i covers [8i+7:8i].
ram_addr  output  ADDR_W  word address = byte address [ADDR_W+1:2].
ram_wdata  output  32  lane-shifted store data.
ram_rdata  input  32  RAM read data, valid one cycle after ram_en with ram_we = 0.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; resp_owner = NONE; starve_cnt = 0; last_grant = DATA. Any read in flight when reset asserts is discarded and produces no rvalid.
- Requesters hold req and fields stable until ready is seen high. A request is consumed in the cycle where ready = 1.
- Misalignment: half with addr[0] = 1, or word with addr[1:0] != 0.
  - d_ready = 1 in that cycle; no RAM access and no grant is consumed.
  - d_err = 1 the next cycle for exactly one cycle; d_rvalid stays 0.
- Arbitration, per cycle, for valid requests only:
  - Only one requester active: it is granted.
  - Both active: data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt:
  - Increments on a data grant while if_req is high, saturating at STARVE_MAX.
  - Clears on any fetch grant, or in any cycle with if_req low.
- Grant cycle drives:
  - ram_en = 1 and ram_addr from the granted address.
  - Loads and fetches: ram_we = 0.
  - Stores: ram_we = 0001 << addr[1:0] for byte, 0011 << {addr[1],0} for half, 1111 for word. ram_wdata = d_wdata replicated so the byte/half lands in the strobed lane(s).
- Read return:
  - resp_owner registers IF or D on a read grant, and NONE on a store, error or idle cycle.
  - The next cycle, the owner's rvalid = 1 and its rdata = ram_rdata. The other requester's rdata holds its last value.
- Stores produce no rvalid. Back-to-back grants every cycle are supported; the response of one grant coincides with the next grant.
- Grant signals (ready, ram_en, ram_we) are combinational from req/state. Everything else is registered.

Optional Feature:
MEM_ARB_RR_EN
- Defined: when both requesters are active, grant the one not recorded in last_grant (strict alternation). starve_cnt is unused and held at 0.
- Undefined: data-priority arbitration with the STARVE_MAX starvation guard, as above.
- last_grant updates on every grant in both builds.

Test Plan:
- Reset mid-read: assert rst_n low the cycle after a fetch grant to 0x40 -> if_rvalid never asserts; all outputs 0 while in reset.
- Fetch only: if_req = 1, if_addr = 0x0000_0010, RAM word 4 = 0xDEADBEEF -> if_ready in cycle 0; ram_addr = 4; if_rvalid = 1 with if_rdata = 0xDEADBEEF in cycle 1.
- Byte store: d_we = 1, d_size = 00, d_addr = 0x0000_0103, d_wdata = 0x0000_00A5 -> ram_we = 1000, ram_wdata[31:24] = 0xA5, ram_addr = 0x040, d_rvalid = 0.
- Half store: d_size = 01, d_addr = 0x0000_0006, d_wdata = 0x0000_1234 -> ram_we = 1100, ram_wdata[31:16] = 0x1234.
- Misaligned word load at d_addr = 0x0000_0002 -> d_ready = 1, ram_en = 0, d_err pulses one cycle, d_rvalid = 0.
- Contention, default build, STARVE_MAX = 4, if_req and d_req held high -> grant order D,D,D,D,IF,D,D,D,D,IF. With MEM_ARB_RR_EN -> D,IF,D,IF. Each response is routed to the correct rvalid.
